// File: rtl/axi4lite_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master engine among NUM_REQ requesters.
// Latency: grant one cycle after request, response one cycle after done; ISSUE aborts after TIMEOUT cycles.
module axi4lite_master_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                      m_axi_aclk,
   input  logic                      m_axi_aresetn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_timeout,
   output logic                      busy,
   output logic                      m_read_ena,
   output logic                      m_write_ena,
   output logic [ADDR_W-1:0]         m_read_addr,
   output logic [ADDR_W-1:0]         m_write_addr,
   output logic [DATA_W-1:0]         m_write_data,
   input  logic [DATA_W-1:0]         m_read_data,
   input  logic                      m_read_done,
   input  logic                      m_write_done
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [PTR_W:0]   NREQ    = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REQ-1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT-1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   gnt_q, gnt_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               tout_q, tout_d;

   logic               any_req;
   logic               done_cur;
   logic               cnt_expired;
   logic [PTR_W-1:0]   arb_idx;
   logic [PTR_W-1:0]   arb_next;
   logic [PTR_W:0]     cand;
   logic               hit;
   logic [NUM_REQ-1:0] gnt_oh;

   assign any_req     = |req_valid;
   assign done_cur    = we_q ? m_write_done : m_read_done;
   assign cnt_expired = (cnt_q == CNT_MAX);
   assign gnt_oh      = NUM_REQ'(1) << gnt_q;
   assign arb_next    = (arb_idx == LAST) ? '0 : arb_idx + 1'b1;

   // Scan requesters starting at ptr, wrapping modulo NUM_REQ.
   always_comb begin
      hit     = 1'b0;
      arb_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (cand >= NREQ) cand = cand - NREQ;
         if (!hit && req_valid[cand[PTR_W-1:0]]) begin
            hit     = 1'b1;
            arb_idx = cand[PTR_W-1:0];
         end
      end
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         tout_q  <= tout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_req) state_d = S_ISSUE;
         S_ISSUE: if (done_cur || cnt_expired) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      tout_d  = tout_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               ptr_d   = arb_next;
               gnt_d   = arb_idx;
               we_d    = req_we[arb_idx];
               addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
               wdata_d = req_wdata[arb_idx*DATA_W +: DATA_W];
               cnt_d   = '0;
               rdata_d = '0;
               tout_d  = 1'b0;
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + 1'b1;
            // Done takes priority over an expiring counter in the same cycle.
            if (done_cur) begin
               rdata_d = we_q ? '0 : m_read_data;
               tout_d  = 1'b0;
            end else if (cnt_expired) begin
               rdata_d = '0;
               tout_d  = 1'b1;
            end
         end
         S_RESP: begin
            cnt_d   = '0;
            rdata_d = '0;
            tout_d  = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      req_ready    = '0;
      rsp_valid    = '0;
      rsp_rdata    = '0;
      rsp_timeout  = 1'b0;
      busy         = 1'b0;
      m_read_ena   = 1'b0;
      m_write_ena  = 1'b0;
      m_read_addr  = '0;
      m_write_addr = '0;
      m_write_data = '0;
      case (state_q)
         S_ISSUE: begin
            busy = 1'b1;
            if (cnt_q == '0) req_ready = gnt_oh;
            // Masking with done keeps the engine from seeing a second start edge.
            m_read_ena  = ~we_q & ~m_read_done;
            m_write_ena =  we_q & ~m_write_done;
            if (we_q) begin
               m_write_addr = addr_q;
               m_write_data = wdata_q;
            end else begin
               m_read_addr = addr_q;
            end
         end
         S_RESP: begin
            busy        = 1'b1;
            rsp_valid   = gnt_oh;
            rsp_rdata   = rdata_q;
            rsp_timeout = tout_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Scoreboard bench: an engine model answers the master port, a monitor checks responses.
module tb_axi4lite_master_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_timeout, busy;
   logic            m_read_ena, m_write_ena;
   logic [AW-1:0]   m_read_addr, m_write_addr;
   logic [DW-1:0]   m_write_data, m_read_data;
   logic            m_read_done, m_write_done;

   axi4lite_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .m_read_ena(m_read_ena), .m_write_ena(m_write_ena),
      .m_read_addr(m_read_addr), .m_write_addr(m_write_addr), .m_write_data(m_write_data),
      .m_read_data(m_read_data), .m_read_done(m_read_done), .m_write_done(m_write_done)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC3C3_0F0F);
   endfunction

   typedef struct {
      int          idx;
      logic [DW-1:0] rdata;
      logic        tout;
   } exp_t;

   exp_t sb_q[$];
   int   grant_log[$];

   bit              eng_active = 0;
   int              eng_k = 0;
   int              eng_L = 0;
   int              eng_g = 0;
   logic            eng_we = 1'b0;
   logic [AW-1:0]   eng_addr = '0;
   logic [DW-1:0]   eng_wdata = '0;
   int              model_ptr = 0;
   int              force_lat = 0;
   bit              rd_done_nxt = 0, wr_done_nxt = 0;
   bit              granted [N];
   bit              hold_all = 0;
   logic [N-1:0]    prev_vld = '0, prev_we = '0;
   logic [N*AW-1:0] prev_addr = '0;
   logic [N*DW-1:0] prev_wdata = '0;

   // Engine model: accepts grants, predicts the response, drives done pulses.
   initial begin
      int  ge, g, end_k, iss_k;
      bit  en_exp;
      m_read_done = 1'b0; m_write_done = 1'b0; m_read_data = '0;
      forever begin
         @(posedge clk); #1;
         m_read_data  = DW'($urandom);
         m_read_done  = 1'b0;
         m_write_done = 1'b0;
         if (eng_active && rst_n) begin
            if (eng_we) begin
               m_write_done = wr_done_nxt;
               m_read_done  = ($urandom_range(0, 3) == 0);
            end else begin
               m_read_done  = rd_done_nxt;
               m_write_done = ($urandom_range(0, 3) == 0);
               if (rd_done_nxt) m_read_data = rd_fn(eng_addr);
            end
         end
         rd_done_nxt = 0;
         wr_done_nxt = 0;

         @(negedge clk);
         if (!rst_n) begin
            eng_active = 0;
            sb_q.delete();
            model_ptr = 0;
         end else begin
            if (!eng_active && req_ready != '0) begin
               ge = -1;
               for (int j = 0; j < N; j++) begin
                  int c;
                  c = (model_ptr + j) % N;
                  if (ge < 0 && prev_vld[c]) ge = c;
               end
               g = -1;
               for (int j = N - 1; j >= 0; j--) if (req_ready[j]) g = j;
               chk("grant_idx", 64'(g), 64'(ge));
               if (ge < 0) ge = g;
               model_ptr  = (ge + 1) % N;
               eng_g      = ge;
               eng_we     = prev_we[ge];
               eng_addr   = prev_addr[ge*AW +: AW];
               eng_wdata  = prev_wdata[ge*DW +: DW];
               eng_L      = (force_lat != 0) ? force_lat : int'($urandom_range(2, 20));
               sb_q.push_back('{idx: ge,
                                rdata: (eng_L > T || eng_we) ? '0 : rd_fn(eng_addr),
                                tout: (eng_L > T)});
               granted[g] = 1;
               grant_log.push_back(g);
               eng_active = 1;
               eng_k      = 1;
            end else if (eng_active) begin
               eng_k++;
            end

            if (eng_active) begin
               iss_k  = (eng_L <= T) ? eng_L : T;
               end_k  = iss_k + 1;
               en_exp = (eng_k < eng_L) && (eng_k <= T);
               chk("req_ready", 64'(req_ready), 64'((eng_k == 1) ? (N'(1) << eng_g) : N'(0)));
               chk("rd_ena", 64'(m_read_ena), 64'(en_exp && !eng_we));
               chk("wr_ena", 64'(m_write_ena), 64'(en_exp && eng_we));
               chk("busy_act", 64'(busy), 64'(1));
               if (eng_k <= iss_k) begin
                  chk("rd_addr", 64'(m_read_addr), 64'(eng_we ? '0 : eng_addr));
                  chk("wr_addr", 64'(m_write_addr), 64'(eng_we ? eng_addr : '0));
                  chk("wr_data", 64'(m_write_data), 64'(eng_we ? eng_wdata : '0));
               end else begin
                  chk("resp_addr0", 64'({m_read_addr, m_write_addr}), 64'(0));
               end
               if (eng_k + 1 == eng_L && eng_L <= T) begin
                  if (eng_we) wr_done_nxt = 1; else rd_done_nxt = 1;
               end
               if (eng_k == end_k) eng_active = 0;
            end else begin
               chk("idle_busy", 64'({busy, m_read_ena, m_write_ena}), 64'(0));
            end
         end
         prev_vld   = req_valid;
         prev_we    = req_we;
         prev_addr  = req_addr;
         prev_wdata = req_wdata;
      end
   end

   // Response monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got rsp_valid=%b required none at %0t", rsp_valid, $time);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << e.idx));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tout));
            end
         end
      end
   end

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         if (granted[i]) begin
            granted[i] = 0;
            if (!hold_all) req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (n < budget && !(req_valid == '0 && !eng_active && sb_q.size() == 0 && !busy));
      if (!(req_valid == '0 && !eng_active && sb_q.size() == 0 && !busy)) begin
         checks++;
         errors++;
         $display("FAIL %s_wait: still busy after %0d cycles, required idle", name, budget);
      end
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_ready"}, 64'(req_ready), 64'(0));
      chk({name, "_rspv"},  64'(rsp_valid), 64'(0));
      chk({name, "_rsp"},   64'({rsp_rdata, rsp_timeout, busy}), 64'(0));
      chk({name, "_ena"},   64'({m_read_ena, m_write_ena}), 64'(0));
      chk({name, "_addr"},  64'({m_read_addr, m_write_addr}), 64'(0));
      chk({name, "_wdata"}, 64'(m_write_data), 64'(0));
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      req_valid = '0;
      for (int i = 0; i < N; i++) granted[i] = 0;
      tick();
      tick();
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < N; i++) granted[i] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      force_lat = 5;
      set_req(2, 1'b0, 32'h0000_0010, 32'h0);
      wait_done(100, "read2");

      force_lat = 4;
      set_req(0, 1'b1, 32'h0000_0004, 32'h1234_5678);
      wait_done(100, "write0");

      // All requesters pending straight out of reset.
      pulse_reset();
      grant_log.delete();
      hold_all = 1;
      force_lat = 2;
      for (int i = 0; i < N; i++) set_req(i, i[0], AW'(32'h100 + i * 4), DW'(32'hA000 + i));
      rst_n = 1'b1;
      n = 0;
      while (grant_log.size() < 6 && n < 200) begin tick(); n++; end
      hold_all = 0;
      req_valid = '0;
      wait_done(200, "rr");
      for (int i = 0; i < 6; i++)
         chk("rr_order", 64'((grant_log.size() > i) ? grant_log[i] : -1), 64'(i % N));

      force_lat = 100;
      set_req(3, 1'b0, 32'h0000_0020, 32'h0);
      wait_done(100, "tmo_rd");
      force_lat = 100;
      set_req(2, 1'b1, 32'h0000_0024, 32'h5555_AAAA);
      wait_done(100, "tmo_wr");
      force_lat = 4;
      set_req(1, 1'b0, 32'h0000_0028, 32'h0);
      wait_done(100, "after_tmo");

      // Reset three cycles into ISSUE; pointer returns to 0.
      force_lat = 50;
      set_req(2, 1'b0, 32'h0000_0030, 32'h0);
      n = 0;
      do begin tick(); n++; end while (!(eng_active && eng_k == 3) && n < 60);
      chk("rst_reach_issue3", 64'(eng_k), 64'(3));
      rst_n = 1'b0;
      req_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("rst_mid");
      @(posedge clk); #1;
      set_req(0, 1'b0, 32'h0000_0040, 32'h0);
      set_req(3, 1'b1, 32'h0000_0044, 32'hCAFE_F00D);
      for (int i = 0; i < N; i++) granted[i] = 0;
      grant_log.delete();
      @(posedge clk); #1;
      force_lat = 3;
      rst_n = 1'b1;
      wait_done(100, "post_rst");
      chk("post_rst_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'(0));
      chk("post_rst_second", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'(3));

      // Done lands on the final counter cycle.
      force_lat = T;
      set_req(1, 1'b0, 32'h0000_0048, 32'h0);
      wait_done(100, "coincide");

      force_lat = 0;
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 3) == 0)
               set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255) * 4), DW'($urandom));
      end
      for (int i = 0; i < N; i++) if (!granted[i]) req_valid[i] = req_valid[i];
      n = 0;
      while (req_valid != '0 && n < 2000) begin tick(); n++; end
      wait_done(2000, "random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4lite_master_arbiter.md
# axi4lite_master_arbiter

Round-robin arbiter and sequencer that shares one AXI4-Lite master engine among `NUM_REQ` on-chip requesters. It accepts single-beat read or write requests and drives the engine's `read_ena`/`write_ena`, address and data inputs for one transaction at a time. It waits for `read_done`/`write_done` and returns read data or a timeout flag to the granted requester. It sits between the register-access clients and the AXI4-Lite master.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: address width; matches the master engine.
- `DATA_W`, 32: data width; matches the master engine.
- `TIMEOUT`, 256: maximum cycles in ISSUE before abort, ≥4.
- `m_axi_aclk`  in  1  single clock; all logic on its rising edge.
- `m_axi_aresetn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data, same packing.
- `req_ready`  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  read data; valid when any `rsp_valid` bit is high.
- `rsp_timeout`  out  1  completion was an abort; qualified by `rsp_valid`.
- `busy`  out  1  high in ISSUE and RESP.
- `m_read_ena`, `m_write_ena`  out  1 each  to the master engine.
- `m_read_addr`  out  ADDR_W  to the master engine.
- `m_write_addr`  out  ADDR_W  to the master engine.
- `m_write_data`  out  DATA_W  to the master engine.
- `m_read_data`  in  DATA_W  from the master engine.
- `m_read_done`, `m_write_done`  in  1 each  completion pulses from the master engine.

## Operation
- States:
  - IDLE → ISSUE when any `req_valid` is high.
  - ISSUE → RESP when the done pulse for the current direction is seen, or on timeout.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE: round-robin starting at pointer `ptr`. Grant `g` is the first i with `req_valid[i]` in order `ptr`, `ptr+1`, …, wrapping modulo NUM_REQ. On grant, `ptr` ← (g+1) mod NUM_REQ.
- On the IDLE→ISSUE edge, latch g, `req_we[g]`, `req_addr[g]` and `req_wdata[g]`.
- ISSUE: the selected enable is held high; the other enable stays 0. `m_*_addr` and `m_write_data` are driven from the latched values and are stable for the whole of ISSUE. Unused address/data outputs are 0.
- Enable output = registered enable AND NOT the matching done input, combinationally. The master therefore sees the enable low at the edge following the done cycle and cannot start a second transaction.
- Read completion: `rsp_rdata` ← `m_read_data`, sampled in the `m_read_done` cycle.
- Write completion: `rsp_rdata` ← 0.
- The done input of the opposite direction is ignored.
- Timeout counter: cleared on ISSUE entry and incremented each ISSUE cycle.
  - When it equals TIMEOUT-1 with no done: drop the enable, go to RESP with `rsp_timeout`=1 and `rsp_rdata`=0.
  - Done and timeout in the same cycle: done wins.
- RESP: `rsp_valid[g]`=1 for exactly one cycle. Both enables are 0, which gives the master at least two idle edges before the next grant.
- Requester changes to `req_valid`/payload after the latch edge are ignored. The transaction always completes or times out.

## Timing
- Reset values, applied at an edge with `m_axi_aresetn`=0 and from any state, mid-transaction included:
  - State = IDLE, `ptr` = 0, counter = 0.
  - All outputs = 0.
  - An aborted in-flight transaction produces no `rsp_valid`.
- Request at edge E0 (sampled in IDLE): ISSUE in cycle E0+1.
  - `req_ready[g]` and the enable are high in that cycle.
  - The requester must hold `valid` and payload through edge E0 and may drop them once `req_ready` is seen.
- Done seen in ISSUE cycle D: the enable is low in cycle D; RESP (`rsp_valid`) in cycle D+1; IDLE in D+2.
- Earliest next grant: sampled at edge D+2, enable high in D+3.
- Back-to-back throughput: one transaction per (master latency + 3) cycles.
- Timeout: at most TIMEOUT cycles of enable, then RESP.

## Test plan
- Single read by requester 2 to 0x0000_0010; slave returns 0xDEAD_BEEF. Expect:
  - `req_ready`=4'b0100 one cycle.
  - `m_read_ena` high until `m_read_done`.
  - `rsp_valid`=4'b0100 with `rsp_rdata`=0xDEAD_BEEF and `rsp_timeout`=0.
- Single write by requester 0 of 0x1234_5678 to 0x0000_0004. Expect:
  - `m_write_addr`/`m_write_data` stable through ISSUE.
  - Exactly one AW and one W handshake on the bus.
  - `rsp_valid`=4'b0001 with `rsp_rdata`=0.
- All 4 requesters assert continuously from reset. Expect grant order 0,1,2,3,0,1, with no requester granted twice before every other pending requester is served.
- Slave never responds, TIMEOUT=16. Expect:
  - The enable drops after 16 ISSUE cycles.
  - `rsp_valid` with `rsp_timeout`=1 and `rsp_rdata`=0.
  - The next request is served normally.
- Reset asserted 3 cycles into an ISSUE. Expect:
  - The next edge gives all outputs 0, `ptr`=0 and no `rsp_valid`.
  - After release, requester 0 wins over requester 3 when both are pending.
- Requester 1 drops `req_valid` during ISSUE and `m_read_done` coincides with the timeout cycle. Expect:
  - The transaction completes normally.
  - `rsp_timeout`=0 and `rsp_rdata` carries the read data.
